simon_zseq_gen_rt: RTL and testbench

Runtime-configurable successor to the compile-time Simon z-sequence generator. One instance serves all ten Simon block/key configurations, selected per operation by a config code, in both encrypt and decrypt.
For decrypt, the block derives the starting point itself by fast-forwarding the sequence, so no per-config decrypt seed constants exist.
It sits beside the key-schedule datapath. It also provides a round counter and last-round/done flags to the round controller.

---
 rtl/simon_pkg.sv | 70 +++++++
 rtl/simon_zseq_gen_rt_lfsr.sv | 40 ++++
 rtl/simon_zseq_gen_rt.sv | 147 ++++++++++++++
 tb/tb_simon_zseq_gen_rt.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, config tables and LFSR matrices for the Simon z-sequence generator
package simon_pkg;

  localparam int NUM_CFG = 10;
  localparam int LN      = 5;
  localparam int NMAT    = 6;

  typedef enum logic [3:0] {
    CFG_32_64   = 4'd0,
    CFG_48_72   = 4'd1,
    CFG_48_96   = 4'd2,
    CFG_64_96   = 4'd3,
    CFG_64_128  = 4'd4,
    CFG_96_96   = 4'd5,
    CFG_96_144  = 4'd6,
    CFG_128_128 = 4'd7,
    CFG_128_192 = 4'd8,
    CFG_128_256 = 4'd9
  } cfg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_READY,
    ST_DONE
  } zseq_state_e;

  // Row i holds the taps of next-state bit i; bit k of a row selects current bit k.
  typedef logic [LN-1:0][LN-1:0] mat_t;

  localparam mat_t MAT_U  = {5'b10001, 5'b10000, 5'b01001, 5'b00100, 5'b00010};
  localparam mat_t MAT_V  = {5'b00001, 5'b10000, 5'b01001, 5'b00100, 5'b00110};
  localparam mat_t MAT_W  = {5'b00001, 5'b10000, 5'b01001, 5'b00100, 5'b00010};
  localparam mat_t MAT_UR = {5'b01000, 5'b11100, 5'b00010, 5'b00001, 5'b11000};
  localparam mat_t MAT_VR = {5'b01000, 5'b10100, 5'b00010, 5'b00011, 5'b10000};
  localparam mat_t MAT_WR = {5'b01000, 5'b10100, 5'b00010, 5'b00001, 5'b10000};

  // Index 0..2 forward (u, v, w); index 3..5 the matching inverses.
  localparam logic [NMAT-1:0][LN-1:0][LN-1:0] LFSR_MATS =
    {MAT_WR, MAT_VR, MAT_UR, MAT_W, MAT_V, MAT_U};

  localparam logic [LN-1:0] ENC_SEED = 5'b10000;

  localparam logic [6:0] ROUNDS [NUM_CFG] =
    '{7'd32, 7'd36, 7'd36, 7'd42, 7'd44, 7'd52, 7'd54, 7'd68, 7'd69, 7'd72};

  localparam logic [2:0] ZSEL [NUM_CFG] =
    '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4};

  function automatic logic is_legal_cfg(input logic [3:0] c);
    return c <= CFG_128_256;
  endfunction

  function automatic logic [6:0] cfg_rounds(input logic [3:0] c);
    logic [6:0] r;
    r = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (c == 4'(k)) r = ROUNDS[k];
    return r;
  endfunction

  function automatic logic [2:0] cfg_zsel(input logic [3:0] c);
    logic [2:0] z;
    z = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (c == 4'(k)) z = ZSEL[k];
    return z;
  endfunction

endpackage

// File: rtl/simon_zseq_gen_rt_lfsr.sv
// rtl/simon_zseq_gen_rt_lfsr.sv - GF(2) matrix-stepped LFSR with one-hot runtime matrix select
module lfsr_multi_config #(
  parameter int N = 5,
  parameter int C = 6,
  parameter logic [C-1:0][N-1:0][N-1:0] MATRICES = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  input  logic [C-1:0] conf_sel,
  output logic         out
);

  logic [N-1:0]        state_q;
  logic [N-1:0]        state_nxt;
  logic [N-1:0][N-1:0] mat;

  always_comb begin
    mat = '0;
    for (int c = 0; c < C; c++)
      if (conf_sel[c]) mat = mat | MATRICES[c];
    state_nxt = '0;
    for (int i = 0; i < N; i++)
      state_nxt[i] = ^(mat[i] & state_q);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      state_q <= '0;
    else if (load)
      state_q <= seed;
    else if (step)
      state_q <= state_nxt;
  end

  assign out = state_q[N-1];

endmodule

// File: rtl/simon_zseq_gen_rt.sv
// rtl/simon_zseq_gen_rt.sv - runtime-configurable Simon z-sequence generator with decrypt fast-forward
module simon_zseq_gen_rt
  import simon_pkg::*;
#(
  parameter int RND_W  = 7,
  parameter int LFSR_N = 5
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [3:0]       cfg_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic             adv_i,
  output logic             z_o,
  output logic [RND_W-1:0] round_o,
  output logic             ready_o,
  output logic             last_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  zseq_state_e      state_q, state_d;
  logic [3:0]       cfg_q, cfg_d;
  logic             mode_q, mode_d;
  logic             t_q, t_d;
  logic             err_q, err_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [RND_W-1:0] seek_q, seek_d;
  logic [RND_W-1:0] t_last;
  logic [2:0]       zsel;
  logic [2:0]       mat_base;
  logic [2:0]       mat_idx;
  logic [NMAT-1:0]  conf_sel;
  logic             rev;
  logic             at_last;
  logic             lfsr_load, lfsr_step, lfsr_out;

  assign t_last  = RND_W'(cfg_rounds(cfg_q)) - RND_W'(1);
  assign zsel    = cfg_zsel(cfg_q);
  assign at_last = (round_q == t_last);

  // Seeking always runs forward; only the decrypt READY phase walks backward.
  assign rev = mode_q & (state_q == ST_READY);

  always_comb begin
    case (zsel)
      3'd0, 3'd2: mat_base = 3'd0;
      3'd1, 3'd3: mat_base = 3'd1;
      default:    mat_base = 3'd2;
    endcase
    mat_idx  = mat_base + (rev ? 3'd3 : 3'd0);
    conf_sel = NMAT'(1) << mat_idx;
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    mode_d    = mode_q;
    t_d       = t_q;
    err_d     = err_q;
    round_d   = round_q;
    seek_d    = seek_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (start_i) begin
      cfg_d     = cfg_i;
      mode_d    = mode_i;
      t_d       = 1'b0;
      round_d   = '0;
      seek_d    = '0;
      lfsr_load = 1'b1;
      err_d     = !is_legal_cfg(cfg_i);
      if (!is_legal_cfg(cfg_i))
        state_d = ST_IDLE;
      else if (mode_i)
        state_d = ST_SEEK;
      else
        state_d = ST_READY;
    end else begin
      case (state_q)
        ST_SEEK: begin
          lfsr_step = 1'b1;
          t_d       = ~t_q;
          if (seek_q == t_last - RND_W'(1))
            state_d = ST_READY;
          else
            seek_d = seek_q + RND_W'(1);
        end
        ST_READY: begin
          if (adv_i) begin
            // The final bit parks the sequence; nothing steps past T-1.
            if (at_last) begin
              state_d = ST_DONE;
            end else begin
              lfsr_step = 1'b1;
              t_d       = ~t_q;
              round_d   = round_q + RND_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      mode_q  <= 1'b0;
      t_q     <= 1'b0;
      err_q   <= 1'b0;
      round_q <= '0;
      seek_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      mode_q  <= mode_d;
      t_q     <= t_d;
      err_q   <= err_d;
      round_q <= round_d;
      seek_q  <= seek_d;
    end
  end

  lfsr_multi_config #(
    .N        (LFSR_N),
    .C        (NMAT),
    .MATRICES (LFSR_MATS)
  ) u_lfsr (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (lfsr_load),
    .seed     (ENC_SEED),
    .step     (lfsr_step),
    .conf_sel (conf_sel),
    .out      (lfsr_out)
  );

  assign z_o       = lfsr_out ^ ((zsel >= 3'd2) & t_q);
  assign round_o   = round_q;
  assign ready_o   = (state_q == ST_READY);
  assign last_o    = ready_o & at_last;
  assign done_o    = (state_q == ST_DONE);
  assign cfg_err_o = err_q;

endmodule

// File: tb/tb_simon_zseq_gen_rt.sv
// tb/tb_simon_zseq_gen_rt.sv - self-checking bench for simon_zseq_gen_rt
module tb_simon_zseq_gen_rt;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [3:0] cfg_i = '0;
  logic       mode_i = 1'b0;
  logic       start_i = 1'b0;
  logic       adv_i = 1'b0;
  logic       z_o;
  logic [6:0] round_o;
  logic       ready_o, last_o, done_o, cfg_err_o;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  simon_zseq_gen_rt #(.RND_W(7), .LFSR_N(5)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cfg_i     (cfg_i),
    .mode_i    (mode_i),
    .start_i   (start_i),
    .adv_i     (adv_i),
    .z_o       (z_o),
    .round_o   (round_o),
    .ready_o   (ready_o),
    .last_o    (last_o),
    .done_o    (done_o),
    .cfg_err_o (cfg_err_o)
  );

  logic [0:61] ZS [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };
  int MT [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  int MJ [10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};

  function automatic logic mz(input int j, input int idx);
    return ZS[j][idx % 62];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sequence-level model: phase 0 idle, 1 seeking, 2 ready, 3 done.
  int m_phase = 0, m_T = 0, m_j = 0, m_round = 0, m_wait = 0;
  bit m_mode = 0, m_err = 0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_phase = 0; m_err = 0; m_round = 0;
    end else if (start_i) begin
      m_round = 0;
      if (cfg_i > 4'd9) begin
        m_err = 1; m_phase = 0;
      end else begin
        m_err = 0; m_T = MT[cfg_i]; m_j = MJ[cfg_i]; m_mode = mode_i;
        m_phase = mode_i ? 1 : 2;
        m_wait = m_T - 1;
      end
    end else if (m_phase == 1) begin
      m_wait--;
      if (m_wait == 0) m_phase = 2;
    end else if (m_phase == 2 && adv_i) begin
      if (m_round == m_T - 1) m_phase = 3;
      else m_round++;
    end
  end

  always @(negedge clk) begin
    if (arst_n && chk_on) begin
      chk("ready", ready_o, m_phase == 2);
      chk("done", done_o, m_phase == 3);
      chk("cfg_err", cfg_err_o, m_err);
      if (m_phase == 2) begin
        chk("round", round_o, m_round);
        chk("last", last_o, m_round == m_T - 1);
        chk("z", z_o, mz(m_j, m_mode ? m_T - 1 - m_round : m_round));
      end
    end
  end

  task automatic do_start(input logic [3:0] c, input logic m, input logic a);
    @(negedge clk);
    cfg_i = c; mode_i = m; start_i = 1'b1; adv_i = a;
    @(negedge clk);
    start_i = 1'b0; adv_i = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int exp);
    int lat;
    lat = 1;
    while (!ready_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, lat, exp);
  endtask

  task automatic run_advs(input int n, output logic [0:127] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      b[i] = z_o;
      adv_i = 1'b1;
      @(negedge clk);
      adv_i = 1'b0;
    end
  endtask

  logic [0:127] bits;
  logic [0:31]  e32;
  logic [0:71]  e72;
  logic [0:35]  e36;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_z", z_o, 0);
    arst_n = 1'b1;
    chk_on = 1'b1;

    do_start(4'd4, 1'b0, 1'b0);
    wait_ready("lat_c4e", 1);
    run_advs(5, bits);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_ready", ready_o, 0);
    chk("arst_round", round_o, 0);
    chk("arst_z", z_o, 0);
    chk("arst_last", last_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_err", cfg_err_o, 0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", ready_o, 0);
    end

    do_start(4'd0, 1'b0, 1'b0);
    wait_ready("lat_c0e", 1);
    run_advs(32, bits);
    e32 = 32'b11111010001001010110000111001101;
    chk("z0_stream", bits[0:31], e32);
    chk("c0_done", done_o, 1);
    chk("c0_ready_off", ready_o, 0);
    adv_i = 1'b1;
    @(negedge clk);
    adv_i = 1'b0;
    chk("c0_done_hold", done_o, 1);
    chk("c0_round_hold", round_o, 31);

    do_start(4'd9, 1'b0, 1'b0);
    wait_ready("lat_c9e", 1);
    run_advs(72, bits);
    e72 = {62'b11010001111001101011011000100000010111000011001010010011101111, 10'b1101000111};
    chk("z4_stream", bits[0:71], e72);

    do_start(4'd4, 1'b1, 1'b0);
    wait_ready("lat_c4d", 44);
    run_advs(44, bits);
    chk("c4d_first", bits[0], 0);
    chk("c4d_last", bits[43], 1);
    chk("c4d_done", done_o, 1);

    do_start(4'd3, 1'b0, 1'b0);
    wait_ready("lat_c3e", 1);
    run_advs(10, bits);
    do_start(4'd8, 1'b1, 1'b1);
    chk("abort_round", round_o, 0);
    chk("abort_ready", ready_o, 0);
    wait_ready("lat_c8d", 69);
    chk("abort_first", z_o, 1);
    run_advs(69, bits);
    chk("c8d_done", done_o, 1);

    do_start(4'd12, 1'b0, 1'b0);
    chk("bad_cfg_err", cfg_err_o, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bad_cfg_idle", ready_o, 0);
    end
    do_start(4'd1, 1'b0, 1'b0);
    chk("err_clear", cfg_err_o, 0);
    wait_ready("lat_c1e", 1);
    run_advs(36, bits);
    e36 = 36'b111110100010010101100001110011011111;
    chk("z0_36", bits[0:35], e36);
    chk("c1_done", done_o, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
